// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one pending FIFO at a time,
// pops its head packet and pushes it to the header's destination(s).
module bus_arbiter #(
    parameter int width = 16,
    parameter int devices = 4,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [devices-1:0]         pndng,
    input  logic [devices*width-1:0]   d_out,
    output logic [devices-1:0]         pop,
    output logic [devices-1:0]         push,
    output logic [width-1:0]           d_in,
    output logic                       busy,
    output logic                       drop,
    output logic [15:0]                pkt_count
);

    localparam int IW = (devices > 1) ? $clog2(devices) : 1;
    localparam logic [devices-1:0] ONE = {{(devices-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gnt;
    logic [width-1:0]  data_reg;

    logic [IW-1:0]     sel;
    logic              found;
    logic [width-1:0]  head;
    logic [7:0]        hdest;
    logic [devices-1:0] gmask;

    // First pending requester at or after ptr, wrapping modulo devices.
    always_comb begin
        int idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < devices; k++) begin
            idx = int'(ptr) + k;
            if (idx >= devices)
                idx = idx - devices;
            if (!found && pndng[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    assign head  = d_out[int'(gnt)*width +: width];
    assign hdest = head[width-1 -: 8];
    assign gmask = ONE << gnt;

    assign d_in = data_reg;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            data_reg  <= '0;
            pkt_count <= '0;
            pop       <= '0;
            push      <= '0;
            drop      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    push <= '0;
                    drop <= 1'b0;
                    if (found) begin
                        gnt   <= sel;
                        pop   <= ONE << sel;
                        state <= POP;
                    end
                end
                POP: begin
                    pop      <= '0;
                    data_reg <= head;
                    // Self-addressed and out-of-range packets are discarded.
                    if (hdest == broadcast) begin
                        push <= ~gmask;
                    end else if (int'(hdest) < devices &&
                                 hdest != 8'(gnt)) begin
                        push <= ONE << hdest;
                    end else begin
                        drop <= 1'b1;
                    end
                    state <= PUSH;
                end
                PUSH: begin
                    push <= '0;
                    drop <= 1'b0;
                    if (!drop)
                        pkt_count <= pkt_count + 16'd1;
                    if (int'(gnt) == devices - 1)
                        ptr <= '0;
                    else
                        ptr <= gnt + IW'(1);
                    state <= IDLE;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    drop  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: transfer, rotation, broadcast,
// drops, mid-transfer reset and counter wrap.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] d_out;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] d_in;
    logic        busy;
    logic        drop;
    logic [15:0] pkt_count;

    int n_run = 0;
    int n_fail = 0;

    bus_arbiter #(.width(16), .devices(4), .broadcast(8'hFF)) dut (
        .clk(clk),
        .reset(reset),
        .pndng(pndng),
        .d_out(d_out),
        .pop(pop),
        .push(push),
        .d_in(d_in),
        .busy(busy),
        .drop(drop),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input int i, input logic [15:0] v);
        d_out[i*16 +: 16] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pndng = '0;
        d_out = '0;
        tick();
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_push", 32'(push), 32'h0);
        check("rst_din", 32'(d_in), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
        check("rst_cnt", 32'(pkt_count), 32'h0);
        reset = 1'b0;

        // single transfer: device 2 -> device 1
        set_head(2, 16'h01AB);
        pndng = 4'b0100;
        tick();
        check("st_pop", 32'(pop), 32'h4);
        check("st_busy", 32'(busy), 32'h1);
        pndng = 4'b0000;
        tick();
        check("st_push", 32'(push), 32'h2);
        check("st_din", 32'(d_in), 32'h01AB);
        check("st_pop0", 32'(pop), 32'h0);
        tick();
        check("st_cnt", 32'(pkt_count), 32'h1);
        check("st_idle", 32'(busy), 32'h0);

        // round-robin from ptr=0, each device sends to its neighbour
        do_reset();
        set_head(0, 16'h0100);
        set_head(1, 16'h0211);
        set_head(2, 16'h0322);
        set_head(3, 16'h0033);
        pndng = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("rr_pop", 32'(pop), 32'(4'b0001 << (k % 4)));
            tick();
            check("rr_push", 32'(push), 32'(4'b0001 << ((k + 1) % 4)));
            if (k == 11)
                pndng = 4'b0000;
            tick();
        end
        check("rr_cnt", 32'(pkt_count), 32'd12);

        // broadcast from device 1
        set_head(1, 16'hFF55);
        pndng = 4'b0010;
        tick();
        check("bc_pop", 32'(pop), 32'h2);
        pndng = 4'b0000;
        tick();
        check("bc_push", 32'(push), 32'hD);
        check("bc_din", 32'(d_in), 32'hFF55);
        tick();
        check("bc_cnt", 32'(pkt_count), 32'd13);

        // out-of-range destination
        set_head(0, 16'h0712);
        pndng = 4'b0001;
        tick();
        check("d1_pop", 32'(pop), 32'h1);
        pndng = 4'b0000;
        tick();
        check("d1_drop", 32'(drop), 32'h1);
        check("d1_push", 32'(push), 32'h0);
        tick();
        check("d1_pulse", 32'(drop), 32'h0);
        check("d1_cnt", 32'(pkt_count), 32'd13);

        // self-addressed
        set_head(0, 16'h0034);
        pndng = 4'b0001;
        tick();
        check("d2_pop", 32'(pop), 32'h1);
        pndng = 4'b0000;
        tick();
        check("d2_drop", 32'(drop), 32'h1);
        check("d2_push", 32'(push), 32'h0);
        tick();
        check("d2_pulse", 32'(drop), 32'h0);
        check("d2_cnt", 32'(pkt_count), 32'd13);

        // reset during POP of device 3
        set_head(3, 16'h0100);
        pndng = 4'b1000;
        tick();
        check("mr_pop", 32'(pop), 32'h8);
        reset = 1'b1;
        #1;
        check("mr_pop0", 32'(pop), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_din", 32'(d_in), 32'h0);
        check("mr_cnt", 32'(pkt_count), 32'h0);
        tick();
        check("mr_push", 32'(push), 32'h0);
        reset = 1'b0;
        tick();
        check("mr_regnt", 32'(pop), 32'h8);
        pndng = 4'b0000;
        tick();
        check("mr_push2", 32'(push), 32'h2);
        tick();
        check("mr_cnt2", 32'(pkt_count), 32'h1);

        // counter wrap
        force dut.pkt_count = 16'hFFFF;
        #1;
        release dut.pkt_count;
        set_head(2, 16'h0100);
        pndng = 4'b0100;
        tick();
        pndng = 4'b0000;
        tick();
        check("wr_push", 32'(push), 32'h2);
        tick();
        check("wr_cnt", 32'(pkt_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
